// File: rtl/prt_dprx_lnk_frm.sv
// DisplayPort receive link framer: decodes per-slot K-code framing, forwards active
// pixel symbols, captures VB-ID/Mvid/Maud and keeps a saturating framing error count.
module prt_dprx_lnk_frm #(
  parameter int P_SPL       = 2,
  parameter int P_SR_PERIOD = 512
) (
  input  logic               LNK_CLK_IN,
  input  logic               LNK_RST_IN,
  input  logic               LNK_LOCK_IN,
  input  logic [P_SPL-1:0]   LNK_K_IN,
  input  logic [P_SPL*8-1:0] LNK_DAT_IN,
  output logic [P_SPL*8-1:0] VID_DAT_OUT,
  output logic [P_SPL-1:0]   VID_DE_OUT,
  output logic               VID_SOL_OUT,
  output logic               VID_EOL_OUT,
  output logic               VID_SOF_OUT,
  output logic [7:0]         VBID_OUT,
  output logic [7:0]         MVID_OUT,
  output logic [7:0]         MAUD_OUT,
  output logic [1:0]         STA_STATE_OUT,
  output logic [7:0]         STA_ERR_CNT_OUT
);

  localparam int SR_W = $clog2(P_SR_PERIOD + 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_SDP    = 2'd3
  } state_t;

  state_t state_reg, state_next;
  state_t slot_state [P_SPL+1];

  logic [P_SPL*8-1:0] dat_reg, dat_next;
  logic [P_SPL-1:0]   de_reg, de_next;
  logic               sol_reg, sol_next;
  logic               eol_reg, eol_next;
  logic               sof_reg, sof_next;
  logic [7:0]         vbid_reg, vbid_next;
  logic [7:0]         mvid_reg, mvid_next;
  logic [7:0]         maud_reg, maud_next;
  logic [1:0]         idx_reg, idx_next;
  logic               pend_reg, pend_next;
  logic [7:0]         err_reg, err_next;
  logic [SR_W-1:0]    sr_cnt_reg, sr_cnt_next;

  logic [P_SPL-1:0] is_bs, is_sr, is_be, is_ss, is_se, is_bad;

  for (genvar gi = 0; gi < P_SPL; gi++) begin : g_dec
    logic [7:0] sym;
    logic       known;
    assign sym   = LNK_DAT_IN[gi*8 +: 8];
    assign known = (sym == 8'hBC) || (sym == 8'h1C) || (sym == 8'hFB) || (sym == 8'h5C) ||
                   (sym == 8'hFD) || (sym == 8'h7C) || (sym == 8'hFE) || (sym == 8'hF7);
    assign is_bs[gi]  = LNK_K_IN[gi] && (sym == 8'hBC);
    assign is_sr[gi]  = LNK_K_IN[gi] && (sym == 8'h1C);
    assign is_be[gi]  = LNK_K_IN[gi] && (sym == 8'hFB);
    assign is_ss[gi]  = LNK_K_IN[gi] && (sym == 8'h5C);
    assign is_se[gi]  = LNK_K_IN[gi] && (sym == 8'hFD);
    assign is_bad[gi] = LNK_K_IN[gi] && !known;
  end

  always_ff @(posedge LNK_CLK_IN) begin
    if (LNK_RST_IN) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  // Slot-by-slot chain: slot_state[s] is the entry state seen by slot s.
  always_comb begin
    state_t st;
    st = state_reg;
    for (int s = 0; s < P_SPL; s++) begin
      slot_state[s] = st;
      if (st == ST_IDLE) begin
        if (is_bs[s] || is_sr[s]) st = ST_BLANK;
      end else if (is_bs[s] || is_sr[s] || is_se[s] || is_bad[s]) begin
        st = ST_BLANK;
      end else if (is_be[s]) begin
        st = (st == ST_BLANK) ? ST_ACTIVE : ST_BLANK;
      end else if (is_ss[s]) begin
        st = (st == ST_BLANK) ? ST_SDP : ST_BLANK;
      end
    end
    slot_state[P_SPL] = st;
    state_next = LNK_LOCK_IN ? slot_state[P_SPL] : ST_IDLE;
  end

  always_comb begin
    logic [7:0] sym;
    logic       err_hit;
    sym         = '0;
    err_hit     = 1'b0;
    dat_next    = '0;
    de_next     = '0;
    sol_next    = 1'b0;
    eol_next    = 1'b0;
    sof_next    = 1'b0;
    vbid_next   = vbid_reg;
    mvid_next   = mvid_reg;
    maud_next   = maud_reg;
    idx_next    = idx_reg;
    pend_next   = pend_reg;
    err_next    = err_reg;
    sr_cnt_next = sr_cnt_reg;
    if (LNK_LOCK_IN) begin
      for (int s = 0; s < P_SPL; s++) begin
        sym     = LNK_DAT_IN[s*8 +: 8];
        err_hit = 1'b0;
        if (is_sr[s]) begin
          sr_cnt_next = '0;
        end else if (is_bs[s]) begin
          if (sr_cnt_next == SR_W'(P_SR_PERIOD)) begin
            sr_cnt_next = '0;
            if (err_next != 8'hFF) err_next = err_next + 8'd1;
          end else begin
            sr_cnt_next = sr_cnt_next + SR_W'(1);
          end
        end
        if (is_bs[s] || is_sr[s]) begin
          idx_next = 2'd0;
          if (slot_state[s] == ST_ACTIVE) eol_next = 1'b1;
        end
        case (slot_state[s])
          ST_BLANK: begin
            if (!LNK_K_IN[s]) begin
              case (idx_next)
                2'd0: begin
                  if (vbid_next[0] && !sym[0]) pend_next = 1'b1;
                  vbid_next = sym;
                  idx_next  = 2'd1;
                end
                2'd1: begin
                  mvid_next = sym;
                  idx_next  = 2'd2;
                end
                2'd2: begin
                  maud_next = sym;
                  idx_next  = 2'd3;
                end
                default: ;
              endcase
            end else if (is_be[s]) begin
              sol_next  = 1'b1;
              sof_next  = sof_next | pend_next;
              pend_next = 1'b0;
            end
            err_hit = is_se[s] || is_bad[s];
          end
          ST_ACTIVE: begin
            if (!LNK_K_IN[s]) begin
              de_next[s]         = 1'b1;
              dat_next[s*8 +: 8] = sym;
            end
            err_hit = is_be[s] || is_ss[s] || is_se[s] || is_bad[s];
          end
          ST_SDP:  err_hit = is_be[s] || is_ss[s] || is_bad[s];
          default: err_hit = 1'b0;
        endcase
        if (err_hit && (err_next != 8'hFF)) err_next = err_next + 8'd1;
      end
    end
  end

  always_ff @(posedge LNK_CLK_IN) begin
    if (LNK_RST_IN) begin
      dat_reg    <= '0;
      de_reg     <= '0;
      sol_reg    <= 1'b0;
      eol_reg    <= 1'b0;
      sof_reg    <= 1'b0;
      vbid_reg   <= '0;
      mvid_reg   <= '0;
      maud_reg   <= '0;
      idx_reg    <= '0;
      pend_reg   <= 1'b0;
      err_reg    <= '0;
      sr_cnt_reg <= '0;
    end else begin
      dat_reg    <= dat_next;
      de_reg     <= de_next;
      sol_reg    <= sol_next;
      eol_reg    <= eol_next;
      sof_reg    <= sof_next;
      vbid_reg   <= vbid_next;
      mvid_reg   <= mvid_next;
      maud_reg   <= maud_next;
      idx_reg    <= idx_next;
      pend_reg   <= pend_next;
      err_reg    <= err_next;
      sr_cnt_reg <= sr_cnt_next;
    end
  end

  assign VID_DAT_OUT     = dat_reg;
  assign VID_DE_OUT      = de_reg;
  assign VID_SOL_OUT     = sol_reg;
  assign VID_EOL_OUT     = eol_reg;
  assign VID_SOF_OUT     = sof_reg;
  assign VBID_OUT        = vbid_reg;
  assign MVID_OUT        = mvid_reg;
  assign MAUD_OUT        = maud_reg;
  assign STA_STATE_OUT   = state_reg;
  assign STA_ERR_CNT_OUT = err_reg;

endmodule

// File: tb/tb_prt_dprx_lnk_frm.sv
// Directed bench for prt_dprx_lnk_frm with two symbols per clock; every step drives
// one cycle of symbols and checks the registered outputs one cycle later.
module tb_prt_dprx_lnk_frm;

  localparam logic [7:0] BS = 8'hBC, SR = 8'h1C, BE = 8'hFB, SS = 8'h5C;
  localparam logic [7:0] SE = 8'hFD, FS = 8'hFE;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock;
  logic [1:0]  k_in;
  logic [15:0] dat_in;
  logic [15:0] vid_dat;
  logic [1:0]  vid_de;
  logic        sol, eol, sof;
  logic [7:0]  vbid, mvid, maud, err_cnt;
  logic [1:0]  state;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  prt_dprx_lnk_frm #(.P_SPL(2), .P_SR_PERIOD(512)) dut (
    .LNK_CLK_IN      (clk),
    .LNK_RST_IN      (rst),
    .LNK_LOCK_IN     (lock),
    .LNK_K_IN        (k_in),
    .LNK_DAT_IN      (dat_in),
    .VID_DAT_OUT     (vid_dat),
    .VID_DE_OUT      (vid_de),
    .VID_SOL_OUT     (sol),
    .VID_EOL_OUT     (eol),
    .VID_SOF_OUT     (sof),
    .VBID_OUT        (vbid),
    .MVID_OUT        (mvid),
    .MAUD_OUT        (maud),
    .STA_STATE_OUT   (state),
    .STA_ERR_CNT_OUT (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle {slot1, slot0}; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic [1:0] k, input logic [7:0] s1, input logic [7:0] s0);
    k_in   = k;
    dat_in = {s1, s0};
    @(posedge clk);
    #1;
    $display("cycle k=%b dat=%h -> st=%0d de=%b dat=%h sol=%b eol=%b sof=%b err=%0d",
             k, {s1, s0}, state, vid_de, vid_dat, sol, eol, sof, err_cnt);
  endtask

  initial begin
    rst = 1'b1; lock = 1'b0; k_in = '0; dat_in = '0;
    cyc(2'b00, 8'h00, 8'h00);
    cyc(2'b00, 8'h00, 8'h00);
    chk("rst_state", state, 0);
    chk("rst_de", vid_de, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_vbid", vbid, 0);
    rst = 1'b0; lock = 1'b1;

    // First line: blanking capture then BE with a pixel in slot 1
    cyc(2'b01, 8'h01, BS);
    chk("bs_state", state, 1);
    chk("vbid_cap", vbid, 8'h01);
    cyc(2'b00, 8'h33, 8'h22);
    chk("mvid_cap", mvid, 8'h22);
    chk("maud_cap", maud, 8'h33);
    cyc(2'b01, 8'hAA, BE);
    chk("sol_1", sol, 1);
    chk("de_1", vid_de, 2'b10);
    chk("dat_1", vid_dat, 16'hAA00);
    chk("act_state", state, 2);
    chk("no_sof_1", sof, 0);
    cyc(2'b00, 8'h77, 8'h66);
    chk("de_full", vid_de, 2'b11);
    chk("dat_full", vid_dat, 16'h7766);
    chk("sol_pulse", sol, 0);
    cyc(2'b10, BS, 8'h55);
    chk("de_eol", vid_de, 2'b01);
    chk("dat_eol", vid_dat, 16'h0055);
    chk("eol_1", eol, 1);
    chk("eol_state", state, 1);

    // VB-ID bit0 1 -> 0 gives SOF on the next BE only
    cyc(2'b00, 8'h11, 8'h00);
    chk("vbid_0", vbid, 8'h00);
    cyc(2'b10, BE, 8'h22);
    chk("sol_sof", sol, 1);
    chk("sof_1", sof, 1);
    chk("de_blank", vid_de, 2'b00);
    cyc(2'b10, BS, 8'h44);
    chk("eol_2", eol, 1);
    cyc(2'b00, 8'h11, 8'h00);
    cyc(2'b10, BE, 8'h22);
    chk("sol_2", sol, 1);
    chk("no_sof_2", sof, 0);

    // BS then BE in one cycle: both pulses
    cyc(2'b11, BE, BS);
    chk("both_eol", eol, 1);
    chk("both_sol", sol, 1);
    chk("both_state", state, 2);
    chk("both_err", err_cnt, 0);

    // Framing errors
    cyc(2'b11, FS, BE);
    chk("be_act_err", err_cnt, 1);
    chk("be_act_state", state, 1);
    cyc(2'b11, BE, SE);
    chk("se_blank_err", err_cnt, 2);
    chk("se_be_sol", sol, 1);
    chk("se_be_state", state, 2);
    cyc(2'b11, SE, SS);
    chk("dbl_err", err_cnt, 4);
    chk("dbl_state", state, 1);

    // SDP payload is not forwarded or captured
    cyc(2'b01, 8'h99, SS);
    chk("sdp_state", state, 3);
    chk("sdp_de", vid_de, 0);
    cyc(2'b10, SE, 8'h12);
    chk("sdp_exit", state, 1);
    chk("sdp_err", err_cnt, 4);
    chk("sdp_vbid", vbid, 8'h00);
    cyc(2'b11, FS, 8'h3C);
    chk("badk_err", err_cnt, 5);
    chk("badk_state", state, 1);

    // Lock loss mid-line
    cyc(2'b11, FS, BE);
    cyc(2'b00, 8'h12, 8'h34);
    chk("pre_lock_de", vid_de, 2'b11);
    lock = 1'b0;
    cyc(2'b00, 8'h56, 8'h78);
    chk("unlock_state", state, 0);
    chk("unlock_de", vid_de, 0);
    chk("unlock_dat", vid_dat, 0);
    chk("unlock_err", err_cnt, 5);
    chk("unlock_mvid", mvid, 8'h11);
    chk("unlock_maud", maud, 8'h22);
    cyc(2'b01, 8'h00, BS);
    chk("unlock_bs", state, 0);

    // SR period: 512 BS fine, 513th is an error; SR restarts the count
    lock = 1'b1;
    cyc(2'b11, FS, SR);
    chk("sr_state", state, 1);
    for (int i = 0; i < 256; i++) cyc(2'b11, BS, BS);
    chk("bs512_err", err_cnt, 5);
    cyc(2'b11, FS, BS);
    chk("bs513_err", err_cnt, 6);
    cyc(2'b11, BS, SR);
    for (int i = 0; i < 255; i++) cyc(2'b11, BS, BS);
    cyc(2'b11, FS, BS);
    chk("sr_bs512_err", err_cnt, 6);

    // Saturation of the error count
    for (int i = 0; i < 124; i++) cyc(2'b11, SE, SE);
    chk("err_254", err_cnt, 254);
    cyc(2'b11, SE, SE);
    chk("err_sat", err_cnt, 255);
    cyc(2'b11, FS, SE);
    chk("err_hold", err_cnt, 255);

    // Reset mid-line overrides everything
    cyc(2'b11, FS, BE);
    cyc(2'b00, 8'hAB, 8'hCD);
    chk("pre_rst_de", vid_de, 2'b11);
    rst = 1'b1;
    cyc(2'b00, 8'hEF, 8'h01);
    chk("mrst_state", state, 0);
    chk("mrst_de", vid_de, 0);
    chk("mrst_dat", vid_dat, 0);
    chk("mrst_err", err_cnt, 0);
    chk("mrst_vbid", vbid, 0);
    chk("mrst_mvid", mvid, 0);
    chk("mrst_maud", maud, 0);
    chk("mrst_sol", sol, 0);
    rst = 1'b0; lock = 1'b0;
    cyc(2'b01, 8'h00, BS);
    chk("nolock_bs", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
